snn_layer_sequencer: RTL and testbench
======================================

// Module: snn_layer_sequencer
// PURPOSE
//  Controller for one fully-connected layer of spiking neurons (N_OUT instances, N_IN synapses each).
//  Phase 1: streams weights into every neuron's weight memory. Phase 2: runs an inference.
//  An inference is T_STEPS timesteps of input spike frames; output spikes are counted per neuron.
//  Reports the winning class (argmax of the spike counts).
//  Sits between the host/DMA streams and the neuron array.
// PARAMETERS
//  N_IN          784  synapses per neuron / input frame width (<=1024, 10-bit weight address)
//  N_OUT         10   neurons in layer / classes
//  WEIGHT_WIDTH  32   signed weight word width
//  T_STEPS       16   timesteps per inference (>=1)
//  CNT_WIDTH     8    per-neuron spike counter width
// PORTS
//  clk           in   1             clock
//  rst           in   1             synchronous active-high reset
//  load_start    in   1             pulse: begin weight load (honoured in IDLE only)
//  infer_start   in   1             pulse: begin inference (IDLE and weights_loaded only)
//  w_valid       in   1             weight stream valid
//  w_ready       out  1             weight stream ready
//  w_data        in   WEIGHT_WIDTH  weight word
//  f_valid       in   1             spike frame valid
//  f_ready       out  1             spike frame ready
//  f_spikes      in   N_IN          input spike frame for one timestep
//  nrn_rst       out  1             neuron reset (rst OR clear pulse)
//  nrn_en        out  1             neuron timestep enable
//  nrn_waddr     out  10            weight write address
//  nrn_wdata     out  WEIGHT_WIDTH  weight write data
//  nrn_wen       out  N_OUT         one-hot per-neuron weight write enable
//  nrn_spike_in  out  N_IN          registered frame driven to all neurons
//  nrn_spike_out in   N_OUT         neuron spike outputs
//  busy          out  1             high in any state but IDLE
//  weights_loaded out 1             set when a full load completes; cleared by rst or load_start
//  res_valid     out  1             one-cycle pulse: result ready
//  res_class     out  $clog2(N_OUT) winning neuron index, held until next result
// BEHAVIOUR
//  Reset values: all outputs 0; nrn_rst=1 while rst; state IDLE; counters 0.
//  States and transitions:
//   IDLE -> LOAD on load_start (load wins if load_start and infer_start arrive together).
//   IDLE -> CLEAR on infer_start && weights_loaded; infer_start with no weights is ignored.
//   LOAD: w_ready=1; each w_valid&&w_ready drives nrn_wen[j]=1, nrn_waddr=i, nrn_wdata=w_data in the same cycle.
//    Order is neuron-major: i counts 0..N_IN-1, then j increments.
//    After word N_IN*N_OUT: weights_loaded=1, next state IDLE. Excess words are not accepted.
//   CLEAR: nrn_rst=1 for one cycle; spike counters zeroed; step=0 -> WAIT_FRAME.
//   WAIT_FRAME: f_ready=1; on handshake latch f_spikes into nrn_spike_in -> STEP.
//   STEP: nrn_en=1 for exactly one cycle -> SAMPLE.
//   SAMPLE: cnt[k] += nrn_spike_out[k], saturating at 2^CNT_WIDTH-1.
//    step==T_STEPS-1 -> SCAN; otherwise step++ -> WAIT_FRAME.
//   SCAN: one counter compared per cycle (N_OUT cycles); ties resolve to lowest index
//    (strict > to replace) -> REPORT.
//   REPORT: res_valid=1, res_class updated, -> IDLE.
//  nrn_spike_in holds the last frame between steps; nrn_en never asserts outside STEP.
//  Inference latency from infer_start with f_valid held high: 1 + 3*T_STEPS + N_OUT + 1 cycles to res_valid.
//  Start pulses are ignored while busy. rst mid-operation returns to IDLE, clears weights_loaded, resets neurons.
//  No res_valid follows an aborted run.
// STRUCTURE
//  snn_pkg: state enum, WADDR_WIDTH=10, index/count width helpers.
//  Sub-module snn_argmax_scan: sequential lowest-index-wins argmax over the count array.
// TESTING
//  1. load_start, N_IN=4, N_OUT=2, 8 words 1..8
//     -> wen=01 addr0..3, then wen=10 addr0..3; weights_loaded=1; 9th word sees w_ready=0.
//  2. infer_start before any load -> busy stays 0, no nrn_rst pulse, no res_valid.
//  3. Neuron1 spikes on 5 steps, neuron0 on 2 (T_STEPS=16) -> res_class=1; latency = 1+48+N_OUT+1 cycles.
//  4. Equal counts 3,3 -> res_class=0. Neuron spiking all 300 steps with CNT_WIDTH=8 -> count saturates at 255.
//  5. f_valid low for 20 cycles mid-run -> nrn_en stays 0, step does not advance; run resumes correctly.
//  6. rst during SAMPLE of step 7 -> IDLE next cycle, weights_loaded=0, no res_valid; simultaneous starts -> LOAD.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

    // Neuron weight memories are addressed with a fixed 10-bit port.
    localparam int WADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_WAIT_FRAME,
        ST_STEP,
        ST_SAMPLE,
        ST_SCAN,
        ST_REPORT
    } state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snn_argmax_scan.sv
// Sequential argmax over the spike counters, one counter per enabled cycle.
// Latency: N_OUT cycles of scan_en; last marks the final cycle, win_idx is valid then.
// Backpressure: none; it advances every cycle scan_en is high and rewinds when it drops.
module snn_argmax_scan
    import snn_pkg::*;
#(
    parameter int N_OUT     = 10,
    parameter int CNT_WIDTH = 8,
    parameter int IDX_W     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             scan_en,
    input  logic [N_OUT-1:0][CNT_WIDTH-1:0]  cnt,
    output logic                             last,
    output logic [IDX_W-1:0]                 win_idx
);

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic                 take;

    // Compare the current counter against the running best; strict > keeps the lowest index on ties.
    always_comb begin
        last       = (idx_q == IDX_W'(N_OUT - 1));
        take       = (idx_q == '0) || (cnt[idx_q] > best_q);
        win_idx    = take ? idx_q : best_idx_q;
        best_d     = take ? cnt[idx_q] : best_q;
        best_idx_d = win_idx;
        idx_d      = '0;
        if (scan_en && !last) begin
            idx_d = idx_q + 1'b1;
        end
        if (!scan_en) begin
            best_d     = best_q;
            best_idx_d = best_idx_q;
        end
    end

    // Scan position and running best.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
        end
    end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Sequences weight load and T_STEPS-frame inference for one spiking layer, then reports argmax.
// Latency: result 1 + 3*T_STEPS + N_OUT + 1 cycles after infer_start when frames arrive back-to-back.
// Backpressure: w_ready only in LOAD, f_ready only while waiting for a frame; stalls extend the run.
module snn_layer_sequencer
    import snn_pkg::*;
#(
    parameter int N_IN         = 784,
    parameter int N_OUT        = 10,
    parameter int WEIGHT_WIDTH = 32,
    parameter int T_STEPS      = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          infer_start,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [WEIGHT_WIDTH-1:0]       w_data,
    input  logic                          f_valid,
    output logic                          f_ready,
    input  logic [N_IN-1:0]               f_spikes,
    output logic                          nrn_rst,
    output logic                          nrn_en,
    output logic [WADDR_WIDTH-1:0]        nrn_waddr,
    output logic [WEIGHT_WIDTH-1:0]       nrn_wdata,
    output logic [N_OUT-1:0]              nrn_wen,
    output logic [N_IN-1:0]               nrn_spike_in,
    input  logic [N_OUT-1:0]              nrn_spike_out,
    output logic                          busy,
    output logic                          weights_loaded,
    output logic                          res_valid,
    output logic [idx_width(N_OUT)-1:0]   res_class
);

    localparam int CLS_W  = idx_width(N_OUT);
    localparam int STEP_W = idx_width(T_STEPS);

    state_e                         state_q, state_d;
    logic [WADDR_WIDTH-1:0]         wi_q, wi_d;
    logic [CLS_W-1:0]               wj_q, wj_d;
    logic [STEP_W-1:0]              step_q, step_d;
    logic [N_OUT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]                spk_q, spk_d;
    logic                           loaded_q, loaded_d;
    logic                           res_valid_q, res_valid_d;
    logic [CLS_W-1:0]               res_class_q, res_class_d;
    logic                           w_hs;
    logic                           scan_last;
    logic [CLS_W-1:0]               scan_win;

    snn_argmax_scan #(
        .N_OUT     (N_OUT),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX_W     (CLS_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .scan_en (state_q == ST_SCAN),
        .cnt     (cnt_q),
        .last    (scan_last),
        .win_idx (scan_win)
    );

    // State decodes and the same-cycle weight write path toward the neurons.
    always_comb begin
        w_ready        = (state_q == ST_LOAD);
        f_ready        = (state_q == ST_WAIT_FRAME);
        nrn_en         = (state_q == ST_STEP);
        nrn_rst        = rst || (state_q == ST_CLEAR);
        busy           = (state_q != ST_IDLE);
        w_hs           = w_valid && w_ready;
        nrn_waddr      = wi_q;
        nrn_wdata      = w_hs ? w_data : '0;
        nrn_wen        = '0;
        if (w_hs) begin
            nrn_wen[wj_q] = 1'b1;
        end
        nrn_spike_in   = spk_q;
        weights_loaded = loaded_q;
        res_valid      = res_valid_q;
        res_class      = res_class_q;
    end

    // Next-state logic: load walks neuron-major, inference steps frame/enable/sample per timestep.
    always_comb begin
        state_d     = state_q;
        wi_d        = wi_q;
        wj_d        = wj_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        spk_d       = spk_q;
        loaded_d    = loaded_q;
        res_valid_d = 1'b0;
        res_class_d = res_class_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    loaded_d = 1'b0;
                    wi_d     = '0;
                    wj_d     = '0;
                end else if (infer_start && loaded_q) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    if (wi_q == WADDR_WIDTH'(N_IN - 1)) begin
                        wi_d = '0;
                        if (wj_q == CLS_W'(N_OUT - 1)) begin
                            wj_d     = '0;
                            loaded_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            wj_d = wj_q + 1'b1;
                        end
                    end else begin
                        wi_d = wi_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                step_d  = '0;
                state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (f_valid) begin
                    spk_d   = f_spikes;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (nrn_spike_out[k] && (cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                if (step_q == STEP_W'(T_STEPS - 1)) begin
                    state_d = ST_SCAN;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    res_class_d = scan_win;
                    res_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wi_q        <= '0;
            wj_q        <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            spk_q       <= '0;
            loaded_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
        end else begin
            state_q     <= state_d;
            wi_q        <= wi_d;
            wj_q        <= wj_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            spk_q       <= spk_d;
            loaded_q    <= loaded_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
        end
    end

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench: small layer (N_IN=4, N_OUT=2) at T_STEPS=16, plus a 300-step copy for saturation.
// Frame generator: neuron k spikes on the first lim_k frames of a run.
module tb_snn_layer_sequencer;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int WW = 32;
    localparam int TA = 16;
    localparam int TB = 300;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          w_valid = 1'b0;
    logic          f_valid = 1'b0;
    logic [WW-1:0] w_data = '0;
    logic          infer_a = 1'b0;
    logic          infer_b = 1'b0;
    int            lim0 = 0;
    int            lim1 = 0;
    int            fcnt_a = 0, fcnt_b = 0, en_a = 0, en_b = 0;
    int            checks = 0;
    int            failures = 0;

    logic          a_w_ready, a_f_ready, a_nrn_rst, a_nrn_en, a_busy, a_loaded, a_res_valid;
    logic [9:0]    a_waddr;
    logic [WW-1:0] a_wdata;
    logic [NO-1:0] a_wen, a_spike_out;
    logic [NI-1:0] a_spike_in, a_fsp;
    logic [0:0]    a_res_class;
    logic          b_w_ready, b_f_ready, b_nrn_rst, b_nrn_en, b_busy, b_loaded, b_res_valid;
    logic [9:0]    b_waddr;
    logic [WW-1:0] b_wdata;
    logic [NO-1:0] b_wen, b_spike_out;
    logic [NI-1:0] b_spike_in, b_fsp;
    logic [0:0]    b_res_class;

    always #5 clk = ~clk;

    assign a_fsp = {2'b00, (fcnt_a < lim1), (fcnt_a < lim0)};
    assign b_fsp = {2'b00, (fcnt_b < lim1), (fcnt_b < lim0)};

    snn_layer_sequencer #(.N_IN(NI), .N_OUT(NO), .WEIGHT_WIDTH(WW), .T_STEPS(TA), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .infer_start(infer_a),
        .w_valid(w_valid), .w_ready(a_w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(a_f_ready), .f_spikes(a_fsp),
        .nrn_rst(a_nrn_rst), .nrn_en(a_nrn_en), .nrn_waddr(a_waddr), .nrn_wdata(a_wdata),
        .nrn_wen(a_wen), .nrn_spike_in(a_spike_in), .nrn_spike_out(a_spike_out),
        .busy(a_busy), .weights_loaded(a_loaded), .res_valid(a_res_valid), .res_class(a_res_class)
    );

    snn_layer_sequencer #(.N_IN(NI), .N_OUT(NO), .WEIGHT_WIDTH(WW), .T_STEPS(TB), .CNT_WIDTH(CW)) u_sat (
        .clk(clk), .rst(rst), .load_start(load_start), .infer_start(infer_b),
        .w_valid(w_valid), .w_ready(b_w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(b_f_ready), .f_spikes(b_fsp),
        .nrn_rst(b_nrn_rst), .nrn_en(b_nrn_en), .nrn_waddr(b_waddr), .nrn_wdata(b_wdata),
        .nrn_wen(b_wen), .nrn_spike_in(b_spike_in), .nrn_spike_out(b_spike_out),
        .busy(b_busy), .weights_loaded(b_loaded), .res_valid(b_res_valid), .res_class(b_res_class)
    );

    // Neuron stubs (spike the cycle after an enable) and frame/enable counters per run.
    always @(posedge clk) begin
        a_spike_out <= a_nrn_rst ? '0 : (a_nrn_en ? a_spike_in[NO-1:0] : '0);
        b_spike_out <= b_nrn_rst ? '0 : (b_nrn_en ? b_spike_in[NO-1:0] : '0);
        if (a_nrn_rst) fcnt_a <= 0; else if (f_valid && a_f_ready) fcnt_a <= fcnt_a + 1;
        if (b_nrn_rst) fcnt_b <= 0; else if (f_valid && b_f_ready) fcnt_b <= fcnt_b + 1;
        if (a_nrn_rst) en_a <= 0; else if (a_nrn_en) en_a <= en_a + 1;
        if (b_nrn_rst) en_b <= 0; else if (b_nrn_en) en_b <= en_b + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_load(input bit with_infer);
        load_start = 1'b1;
        if (with_infer) infer_a = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        infer_a = 1'b0;
        #1;
        check("load w_ready", a_w_ready, 1);
        check("load f_ready", a_f_ready, 0);
        check("load busy", a_busy, 1);
        check("load loaded_cleared", a_loaded, 0);
        check("load no_nrn_rst", a_nrn_rst, 0);
        for (int k = 0; k < NI * NO; k++) begin
            w_valid = 1'b1;
            w_data  = WW'(k + 1);
            #1;
            check("load wen", a_wen, (k < NI) ? 1 : 2);
            check("load waddr", a_waddr, k % NI);
            check("load wdata", a_wdata, k + 1);
            check("load b_wen", b_wen, (k < NI) ? 1 : 2);
            check("load b_waddr", b_waddr, k % NI);
            check("load b_wdata", b_wdata, k + 1);
            @(negedge clk);
        end
        w_data = WW'(9);
        #1;
        check("load excess w_ready", a_w_ready, 0);
        check("load excess b_w_ready", b_w_ready, 0);
        check("load excess wen", a_wen, 0);
        check("load weights_loaded", a_loaded, 1);
        check("load b_weights_loaded", b_loaded, 1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic run_inf(input int sel, input int l0, input int l1, input int exp_cls, input string tag);
        int n;
        int t;
        t = sel ? TB : TA;
        lim0 = l0;
        lim1 = l1;
        f_valid = 1'b1;
        if (sel != 0) infer_b = 1'b1; else infer_a = 1'b1;
        @(negedge clk);
        infer_a = 1'b0;
        infer_b = 1'b0;
        n = 1;
        while (!((sel != 0) ? b_res_valid : a_res_valid) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 1 + 3 * t + NO + 1);
        check({tag, " class"}, (sel != 0) ? b_res_class : a_res_class, exp_cls);
        check({tag, " en_pulses"}, (sel != 0) ? en_b : en_a, t);
        @(negedge clk);
        check({tag, " res_valid_one_cycle"}, (sel != 0) ? b_res_valid : a_res_valid, 0);
        check({tag, " idle_after"}, (sel != 0) ? b_busy : a_busy, 0);
        check({tag, " class_held"}, (sel != 0) ? b_res_class : a_res_class, exp_cls);
        f_valid = 1'b0;
    endtask

    typedef struct {
        int    l0;
        int    l1;
        int    cls;
        string name;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   n;
        bit   bad;
        bit   en_seen;

        vecs[0] = '{2, 5, 1, "n1_wins_5v2"};
        vecs[1] = '{3, 3, 0, "tie_3v3"};
        vecs[2] = '{5, 2, 0, "n0_wins_5v2"};
        vecs[3] = '{0, 0, 0, "silent"};
        vecs[4] = '{16, 15, 0, "n0_all_steps"};
        vecs[5] = '{4, 16, 1, "n1_all_steps"};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset nrn_rst_during_rst", a_nrn_rst, 1);
        rst = 1'b0;
        #1;
        check("reset busy", a_busy, 0);
        check("reset weights_loaded", a_loaded, 0);
        check("reset res_valid", a_res_valid, 0);
        check("reset res_class", a_res_class, 0);
        check("reset w_ready", a_w_ready, 0);
        check("reset f_ready", a_f_ready, 0);
        check("reset nrn_en", a_nrn_en, 0);
        check("reset nrn_rst", a_nrn_rst, 0);
        check("reset nrn_wen", a_wen, 0);
        check("reset nrn_waddr", a_waddr, 0);
        check("reset nrn_spike_in", a_spike_in, 0);

        // Inference without weights is ignored
        @(negedge clk);
        infer_a = 1'b1;
        f_valid = 1'b1;
        @(negedge clk);
        infer_a = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            #1;
            if (a_busy || a_nrn_rst || a_res_valid) bad = 1'b1;
            @(negedge clk);
        end
        check("noweights ignored", bad, 0);
        f_valid = 1'b0;

        // Weight load into both instances
        do_load(1'b0);

        // Table of inference runs on the 16-step layer
        for (int i = 0; i < 6; i++) begin
            run_inf(0, vecs[i].l0, vecs[i].l1, vecs[i].cls, vecs[i].name);
        end

        // Counter saturation on the 300-step layer
        run_inf(1, 200, 300, 1, "sat_200v300");
        run_inf(1, 300, 255, 0, "sat_tie_300v255");

        // Frame stall of 20 cycles in the middle of a run
        lim0 = 6;
        lim1 = 9;
        f_valid = 1'b1;
        infer_a = 1'b1;
        @(negedge clk);
        infer_a = 1'b0;
        n = 1;
        while (!(a_f_ready && en_a == 4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        f_valid = 1'b0;
        en_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            n++;
            if (a_nrn_en) en_seen = 1'b1;
        end
        check("stall nrn_en_quiet", en_seen, 0);
        check("stall step_frozen", en_a, 4);
        check("stall still_waiting", a_f_ready, 1);
        f_valid = 1'b1;
        while (!a_res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall latency", n, 1 + 3 * TA + NO + 1 + 20);
        check("stall class", a_res_class, 1);
        check("stall en_pulses", en_a, TA);
        @(negedge clk);
        f_valid = 1'b0;

        // Simultaneous starts with weights present: load wins
        do_load(1'b1);

        // Reset during SAMPLE of step 7
        lim0 = 16;
        lim1 = 16;
        f_valid = 1'b1;
        infer_a = 1'b1;
        @(negedge clk);
        infer_a = 1'b0;
        n = 1;
        while (!(en_a == 8 && !a_f_ready && !a_nrn_en) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort reach_sample7", n, 1 + 3 * 7 + 3);
        rst = 1'b1;
        #1;
        check("abort nrn_rst", a_nrn_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", a_busy, 0);
        check("abort weights_loaded", a_loaded, 0);
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (a_res_valid || a_busy) bad = 1'b1;
        end
        check("abort no_res_valid", bad, 0);
        f_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
